// File: rtl/train_phase_sequencer.sv
// Training-run sequencer: walks LOAD once, then FWD/SIG/BWD per epoch, emitting
// registered datapath enables and row/column indices; stall freezes sequencing.
module train_phase_sequencer #(
    parameter int unsigned N_ROWS = 784,
    parameter int unsigned N_COLS = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] epochs,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase,
    output logic       en_load,
    output logic       en_fwd,
    output logic       en_sig,
    output logic       en_bwd,
    output logic [9:0] row_idx,
    output logic [5:0] col_idx,
    output logic       acc_clear,
    output logic [7:0] epoch_cnt
);

    localparam int unsigned RW = 10;
    localparam int unsigned CW = 6;
    localparam int unsigned EW = 8;
    localparam logic [RW-1:0] ROW_LAST = RW'(N_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FWD  = 3'd2,
        S_SIG  = 3'd3,
        S_BWD  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [EW-1:0] epoch_q, epoch_d;
    logic [EW-1:0] lat_q, lat_d;
    logic          step_q, step_d;
    logic [3:0]    en_q, en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          acc_q, acc_d;
    logic          last;

    // Enable bits ordered {load, fwd, sig, bwd}
    function automatic logic [3:0] en_of(input state_t s);
        case (s)
            S_LOAD:  return 4'b1000;
            S_FWD:   return 4'b0100;
            S_SIG:   return 4'b0010;
            S_BWD:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            epoch_q <= '0;
            lat_q   <= '0;
            step_q  <= 1'b0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            epoch_q <= epoch_d;
            lat_q   <= lat_d;
            step_q  <= step_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
        end
    end

    // step_q marks that the displayed step has already been issued with its enable;
    // after a stall the sequencer advances rather than reissuing the step.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        epoch_d = epoch_q;
        lat_d   = lat_q;
        step_d  = step_q;
        en_d    = 4'b0000;
        last    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                    col_d   = '0;
                    epoch_d = '0;
                    lat_d   = (epochs == '0) ? EW'(1) : epochs;
                    en_d    = stall ? 4'b0000 : 4'b1000;
                    step_d  = !stall;
                end
            end
            S_LOAD, S_FWD, S_SIG, S_BWD: begin
                if (!stall) begin
                    step_d = 1'b1;
                    if (!step_q) begin
                        en_d = en_of(state_q);
                    end else begin
                        case (state_q)
                            S_LOAD, S_FWD: begin
                                if (row_q == ROW_LAST) begin
                                    row_d = '0;
                                    if (col_q == COL_LAST) last = 1'b1;
                                    else col_d = col_q + CW'(1);
                                end else begin
                                    row_d = row_q + RW'(1);
                                end
                            end
                            S_SIG: begin
                                if (col_q == COL_LAST) last = 1'b1;
                                else col_d = col_q + CW'(1);
                            end
                            default: begin
                                if (col_q == COL_LAST) begin
                                    col_d = '0;
                                    if (row_q == ROW_LAST) last = 1'b1;
                                    else row_d = row_q + RW'(1);
                                end else begin
                                    col_d = col_q + CW'(1);
                                end
                            end
                        endcase
                        if (last) begin
                            row_d = '0;
                            col_d = '0;
                            case (state_q)
                                S_LOAD:  state_d = S_FWD;
                                S_FWD:   state_d = S_SIG;
                                S_SIG:   state_d = S_BWD;
                                default: begin
                                    epoch_d = epoch_q + EW'(1);
                                    state_d = (epoch_d < lat_q) ? S_FWD : S_DONE;
                                end
                            endcase
                        end
                        en_d = en_of(state_d);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);
    assign done_d = (state_d == S_DONE);
    assign acc_d  = en_d[2] && (row_d == '0);

    assign phase     = state_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign en_load   = en_q[3];
    assign en_fwd    = en_q[2];
    assign en_sig    = en_q[1];
    assign en_bwd    = en_q[0];
    assign row_idx   = row_q;
    assign col_idx   = col_q;
    assign acc_clear = acc_q;
    assign epoch_cnt = epoch_q;

endmodule

// File: tb/tb_train_phase_sequencer.sv
// Directed bench for train_phase_sequencer with a 4x3 geometry: compares every
// cycle of each run against a hand-built expected trace.
module tb_train_phase_sequencer;

    localparam int unsigned NR = 4;
    localparam int unsigned NC = 3;

    logic       clk = 1'b0;
    logic       rst, start, stall;
    logic [7:0] epochs;
    logic       busy, done, en_load, en_fwd, en_sig, en_bwd, acc_clear;
    logic [2:0] phase;
    logic [9:0] row_idx;
    logic [5:0] col_idx;
    logic [7:0] epoch_cnt;

    int checks   = 0;
    int failures = 0;

    logic [63:0] tq[$];
    int idx_stall, idx_rst, idx_sig, idx_done;

    train_phase_sequencer #(.N_ROWS(NR), .N_COLS(NC)) dut (
        .clk(clk), .rst(rst), .start(start), .epochs(epochs), .stall(stall),
        .busy(busy), .done(done), .phase(phase),
        .en_load(en_load), .en_fwd(en_fwd), .en_sig(en_sig), .en_bwd(en_bwd),
        .row_idx(row_idx), .col_idx(col_idx), .acc_clear(acc_clear),
        .epoch_cnt(epoch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Packed snapshot: {phase, row, col, en{load,fwd,sig,bwd}, acc, busy, done, epoch}
    function automatic logic [63:0] pk(input int ph, input int r, input int c,
                                       input logic [3:0] en, input logic acc,
                                       input logic bz, input logic dn, input int ep);
        return {30'd0, 3'(ph), 10'(r), 6'(c), en, acc, bz, dn, 8'(ep)};
    endfunction

    function automatic logic [63:0] obs();
        return pk(int'(phase), int'(row_idx), int'(col_idx),
                  {en_load, en_fwd, en_sig, en_bwd}, acc_clear, busy, done, int'(epoch_cnt));
    endfunction

    task automatic build(input int ep, input bit with_stall);
        int e;
        e = (ep == 0) ? 1 : ep;
        tq.delete();
        idx_stall = -1; idx_rst = -1; idx_sig = -1; idx_done = -1;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                tq.push_back(pk(1, r, c, 4'b1000, 1'b0, 1'b1, 1'b0, 0));
        for (int p = 0; p < e; p++) begin
            for (int c = 0; c < NC; c++)
                for (int r = 0; r < NR; r++) begin
                    tq.push_back(pk(2, r, c, 4'b0100, r == 0, 1'b1, 1'b0, p));
                    if (p == 0 && c == 1 && r == 2) begin
                        idx_stall = tq.size() - 1;
                        if (with_stall)
                            repeat (5) tq.push_back(pk(2, r, c, 4'b0000, 1'b0, 1'b1, 1'b0, p));
                    end
                end
            for (int c = 0; c < NC; c++) begin
                if (p == 0 && c == 0) idx_sig = tq.size();
                tq.push_back(pk(3, 0, c, 4'b0010, 1'b0, 1'b1, 1'b0, p));
            end
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++) begin
                    if (p == 0 && r == 2 && c == 1) idx_rst = tq.size();
                    tq.push_back(pk(4, r, c, 4'b0001, 1'b0, 1'b1, 1'b0, p));
                end
        end
        idx_done = tq.size();
        tq.push_back(pk(5, 0, 0, 4'b0000, 1'b0, 1'b1, 1'b1, e));
        tq.push_back(pk(0, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, e));
    endtask

    task automatic run(input string name, input int ep, input bit with_stall,
                       input bit poke, input bit do_rst, input int exp_busy);
        int nb, nd, n;
        nb = 0;
        nd = 0;
        build(ep, with_stall);
        epochs = 8'(ep);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        epochs = 8'd7;
        n = do_rst ? idx_rst + 1 : tq.size();
        for (int i = 0; i < n; i++) begin
            check(name, obs(), tq[i]);
            nb += int'(busy);
            nd += int'(done);
            stall = with_stall && (i >= idx_stall) && (i < idx_stall + 5);
            start = poke && (i == idx_sig || i == idx_done);
            rst   = do_rst && (i == idx_rst);
            @(posedge clk); #1;
        end
        start = 1'b0;
        stall = 1'b0;
        rst   = 1'b0;
        if (do_rst)
            check({name, " reset"}, obs(), pk(0, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 0));
        check({name, " done_pulses"}, 64'(nd), do_rst ? 64'd0 : 64'd1);
        if (!do_rst)
            check({name, " busy_cycles"}, 64'(nb), 64'(exp_busy));
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stall  = 1'b0;
        epochs = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs(), pk(0, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle", obs(), pk(0, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 0));

        run("ep1",      1, 1'b0, 1'b0, 1'b0, 40);
        run("ep2",      2, 1'b0, 1'b0, 1'b0, 67);
        run("ep0",      0, 1'b0, 1'b0, 1'b0, 40);
        run("stall",    1, 1'b1, 1'b0, 1'b0, 45);
        run("abort",    1, 1'b0, 1'b0, 1'b1, 0);
        run("post_rst", 1, 1'b0, 1'b0, 1'b0, 40);
        run("poke",     1, 1'b0, 1'b1, 1'b0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
